// File: rtl/data_sram_sync_if.sv
// Load/store-unit side bus of the data SRAM: chip select, request strobes,
// address/data in, registered read data and status strobes back.
interface data_sram_sync_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic              CS_D;
  logic              WD;
  logic              RD;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] DOUT;
  logic              DOUT_VLD;
  logic              BUSY;
  logic              ERR;

  modport master (output CS_D, WD, RD, ADDR, DIN, input DOUT, DOUT_VLD, BUSY, ERR);
  modport slave  (input CS_D, WD, RD, ADDR, DIN, output DOUT, DOUT_VLD, BUSY, ERR);
endinterface

// File: rtl/data_sram_sync.sv
// Clocked data SRAM with registered read port, post-reset clear sequence
// (INIT_VAL to every word) and one-cycle ERR on refused accesses.
module data_sram_sync #(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 7,
  parameter int              DEPTH    = 128,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic            CLK,
  input  logic            RST,
  data_sram_sync_if.slave bus
);
  // One extra bit so DEPTH == 2**ADDR_W is representable for range checks.
  localparam int              PTR_W   = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic              dout_vld_q, err_q;

  logic              req, in_range;
  logic              mem_we, rd_hit, err_d;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign req      = !bus.CS_D && (bus.WD || bus.RD);
  assign in_range = {1'b0, bus.ADDR} < DEPTH_P;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q[ADDR_W-1:0];
    mem_wdata = INIT_VAL;
    rd_hit    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + PTR_W'(1);
        err_d  = req;
        if (ptr_q == LAST_P) state_d = ST_READY;
      end
      ST_READY: begin
        if (req) begin
          if ((bus.WD && bus.RD) || !in_range) begin
            err_d = 1'b1;
          end else if (bus.WD) begin
            mem_we    = 1'b1;
            mem_waddr = bus.ADDR;
            mem_wdata = bus.DIN;
          end else begin
            rd_hit = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array is left untouched on a reset edge; the clear sequence rewrites it.
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dout_vld_q <= rd_hit;
      err_q      <= err_d;
      if (rd_hit) dout_q <= mem[bus.ADDR];
    end
  end

  assign bus.DOUT     = dout_q;
  assign bus.DOUT_VLD = dout_vld_q;
  assign bus.ERR      = err_q;
  assign bus.BUSY     = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_data_sram_sync.sv
// Directed bench: three instances cover the default 128-deep array, a
// 96-deep array (out-of-range) and a 32-bit x 16 configuration.
module tb_data_sram_sync;
  logic CLK = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 CLK = ~CLK;

  data_sram_sync_if #(.DATA_W(8),  .ADDR_W(7)) ifa ();
  data_sram_sync_if #(.DATA_W(8),  .ADDR_W(7)) ifb ();
  data_sram_sync_if #(.DATA_W(32), .ADDR_W(4)) ifc ();

  data_sram_sync #(.DATA_W(8), .ADDR_W(7), .DEPTH(128), .INIT_VAL(8'hA5))
    u_a (.CLK(CLK), .RST(rst_a), .bus(ifa.slave));
  data_sram_sync #(.DATA_W(8), .ADDR_W(7), .DEPTH(96), .INIT_VAL(8'h3C))
    u_b (.CLK(CLK), .RST(rst_b), .bus(ifb.slave));
  data_sram_sync #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .INIT_VAL(32'h1234_5678))
    u_c (.CLK(CLK), .RST(rst_c), .bus(ifc.slave));

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv_a(input logic cs, input logic wd, input logic rd,
                       input logic [6:0] addr, input logic [7:0] din);
    ifa.CS_D = cs; ifa.WD = wd; ifa.RD = rd; ifa.ADDR = addr; ifa.DIN = din;
  endtask

  task automatic drv_b(input logic cs, input logic wd, input logic rd,
                       input logic [6:0] addr, input logic [7:0] din);
    ifb.CS_D = cs; ifb.WD = wd; ifb.RD = rd; ifb.ADDR = addr; ifb.DIN = din;
  endtask

  task automatic drv_c(input logic cs, input logic wd, input logic rd,
                       input logic [3:0] addr, input logic [31:0] din);
    ifc.CS_D = cs; ifc.WD = wd; ifc.RD = rd; ifc.ADDR = addr; ifc.DIN = din;
  endtask

  task automatic test_reset();
    int n;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    cyc(); cyc();
    total_cnt++;
    if ({ifa.DOUT, ifa.DOUT_VLD, ifa.ERR, ifa.BUSY} !== {8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state dout=%h vld=%b err=%b busy=%b want 00/0/0/1",
               ifa.DOUT, ifa.DOUT_VLD, ifa.ERR, ifa.BUSY);
    else pass_cnt++;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    n = 0;
    while (ifa.BUSY === 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    total_cnt++;
    if (n !== 128) $display("FAIL clear_len busy_edges=%0d want 128", n);
    else pass_cnt++;
  endtask

  task automatic test_clear_values();
    logic [6:0] addrs [3] = '{7'd0, 7'd64, 7'd127};
    for (int i = 0; i < 3; i++) begin
      drv_a(1'b0, 1'b0, 1'b1, addrs[i], 8'h00);
      cyc();
      total_cnt++;
      if ({ifa.DOUT, ifa.DOUT_VLD, ifa.ERR} !== {8'hA5, 1'b1, 1'b0})
        $display("FAIL clear_read[%0d] dout=%h vld=%b err=%b want a5/1/0",
                 addrs[i], ifa.DOUT, ifa.DOUT_VLD, ifa.ERR);
      else pass_cnt++;
    end
    drv_a(1'b1, 1'b0, 1'b0, 7'd0, 8'h00);
    cyc();
    total_cnt++;
    if ({ifa.DOUT, ifa.DOUT_VLD} !== {8'hA5, 1'b0})
      $display("FAIL clear_idle dout=%h vld=%b want a5/0", ifa.DOUT, ifa.DOUT_VLD);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drv_a(1'b0, 1'b1, 1'b0, 7'd0, 8'h01); cyc();
    total_cnt++;
    if ({ifa.DOUT_VLD, ifa.ERR} !== 2'b00)
      $display("FAIL write_strobes vld=%b err=%b want 0/0", ifa.DOUT_VLD, ifa.ERR);
    else pass_cnt++;
    drv_a(1'b0, 1'b1, 1'b0, 7'd1, 8'h03); cyc();
    drv_a(1'b0, 1'b0, 1'b1, 7'd0, 8'h00); cyc();
    total_cnt++;
    if ({ifa.DOUT, ifa.DOUT_VLD} !== {8'h01, 1'b1})
      $display("FAIL b2b_rd0 dout=%h vld=%b want 01/1", ifa.DOUT, ifa.DOUT_VLD);
    else pass_cnt++;
    drv_a(1'b0, 1'b0, 1'b1, 7'd1, 8'h00); cyc();
    total_cnt++;
    if ({ifa.DOUT, ifa.DOUT_VLD} !== {8'h03, 1'b1})
      $display("FAIL b2b_rd1 dout=%h vld=%b want 03/1", ifa.DOUT, ifa.DOUT_VLD);
    else pass_cnt++;
    drv_a(1'b1, 1'b0, 1'b1, 7'd0, 8'h00); cyc();
    total_cnt++;
    if ({ifa.DOUT, ifa.DOUT_VLD} !== {8'h03, 1'b0})
      $display("FAIL b2b_hold dout=%h vld=%b want 03/0", ifa.DOUT, ifa.DOUT_VLD);
    else pass_cnt++;
  endtask

  task automatic test_raw();
    drv_a(1'b0, 1'b1, 1'b0, 7'd10, 8'h5C); cyc();
    drv_a(1'b0, 1'b0, 1'b1, 7'd10, 8'h00); cyc();
    total_cnt++;
    if ({ifa.DOUT, ifa.DOUT_VLD} !== {8'h5C, 1'b1})
      $display("FAIL raw dout=%h vld=%b want 5c/1", ifa.DOUT, ifa.DOUT_VLD);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    drv_a(1'b0, 1'b1, 1'b1, 7'd0, 8'hFF); cyc();
    total_cnt++;
    if ({ifa.ERR, ifa.DOUT_VLD, ifa.DOUT} !== {1'b1, 1'b0, 8'h5C})
      $display("FAIL conflict err=%b vld=%b dout=%h want 1/0/5c", ifa.ERR, ifa.DOUT_VLD, ifa.DOUT);
    else pass_cnt++;
    drv_a(1'b0, 1'b0, 1'b1, 7'd0, 8'h00); cyc();
    total_cnt++;
    if ({ifa.ERR, ifa.DOUT_VLD, ifa.DOUT} !== {1'b0, 1'b1, 8'h01})
      $display("FAIL conflict_nowrite err=%b vld=%b dout=%h want 0/1/01", ifa.ERR, ifa.DOUT_VLD, ifa.DOUT);
    else pass_cnt++;
    drv_a(1'b1, 1'b0, 1'b0, 7'd0, 8'h00);
    // 96-deep instance: in-range write, then out-of-range requests at 100 and 96.
    drv_b(1'b0, 1'b1, 1'b0, 7'd5, 8'h77); cyc();
    drv_b(1'b0, 1'b0, 1'b1, 7'd5, 8'h00); cyc();
    total_cnt++;
    if ({ifb.DOUT, ifb.DOUT_VLD} !== {8'h77, 1'b1})
      $display("FAIL b_rd5 dout=%h vld=%b want 77/1", ifb.DOUT, ifb.DOUT_VLD);
    else pass_cnt++;
    drv_b(1'b0, 1'b1, 1'b0, 7'd100, 8'h11); cyc();
    total_cnt++;
    if ({ifb.ERR, ifb.DOUT_VLD, ifb.DOUT} !== {1'b1, 1'b0, 8'h77})
      $display("FAIL oor_wr100 err=%b vld=%b dout=%h want 1/0/77", ifb.ERR, ifb.DOUT_VLD, ifb.DOUT);
    else pass_cnt++;
    drv_b(1'b0, 1'b0, 1'b1, 7'd96, 8'h00); cyc();
    total_cnt++;
    if ({ifb.ERR, ifb.DOUT_VLD, ifb.DOUT} !== {1'b1, 1'b0, 8'h77})
      $display("FAIL oor_rd96 err=%b vld=%b dout=%h want 1/0/77", ifb.ERR, ifb.DOUT_VLD, ifb.DOUT);
    else pass_cnt++;
    drv_b(1'b0, 1'b0, 1'b1, 7'd95, 8'h00); cyc();
    total_cnt++;
    if ({ifb.ERR, ifb.DOUT_VLD, ifb.DOUT} !== {1'b0, 1'b1, 8'h3C})
      $display("FAIL b_rd95 err=%b vld=%b dout=%h want 0/1/3c", ifb.ERR, ifb.DOUT_VLD, ifb.DOUT);
    else pass_cnt++;
    drv_b(1'b1, 1'b0, 1'b0, 7'd0, 8'h00); cyc();
    total_cnt++;
    if ({ifb.ERR, ifb.DOUT_VLD, ifb.DOUT} !== {1'b0, 1'b0, 8'h3C})
      $display("FAIL b_idle err=%b vld=%b dout=%h want 0/0/3c", ifb.ERR, ifb.DOUT_VLD, ifb.DOUT);
    else pass_cnt++;
  endtask

  task automatic test_mid_clear();
    int n;
    rst_a = 1'b1; cyc();
    rst_a = 1'b0;
    for (int i = 0; i < 49; i++) cyc();
    drv_a(1'b0, 1'b1, 1'b0, 7'd3, 8'hEE); cyc();
    total_cnt++;
    if ({ifa.ERR, ifa.BUSY, ifa.DOUT_VLD} !== {1'b1, 1'b1, 1'b0})
      $display("FAIL busy_req err=%b busy=%b vld=%b want 1/1/0", ifa.ERR, ifa.BUSY, ifa.DOUT_VLD);
    else pass_cnt++;
    // ptr is 50 now; reset with a request still on the bus.
    rst_a = 1'b1; drv_a(1'b0, 1'b0, 1'b1, 7'd3, 8'h00); cyc();
    total_cnt++;
    if ({ifa.ERR, ifa.BUSY, ifa.DOUT_VLD} !== {1'b0, 1'b1, 1'b0})
      $display("FAIL rst_drop err=%b busy=%b vld=%b want 0/1/0", ifa.ERR, ifa.BUSY, ifa.DOUT_VLD);
    else pass_cnt++;
    rst_a = 1'b0; drv_a(1'b1, 1'b0, 1'b0, 7'd0, 8'h00);
    n = 0;
    while (ifa.BUSY === 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    total_cnt++;
    if (n !== 128) $display("FAIL reclear_len busy_edges=%0d want 128", n);
    else pass_cnt++;
    drv_a(1'b0, 1'b0, 1'b1, 7'd10, 8'h00); cyc();
    total_cnt++;
    if ({ifa.DOUT, ifa.DOUT_VLD} !== {8'hA5, 1'b1})
      $display("FAIL reclear_rd10 dout=%h vld=%b want a5/1", ifa.DOUT, ifa.DOUT_VLD);
    else pass_cnt++;
    drv_a(1'b1, 1'b0, 1'b0, 7'd0, 8'h00);
  endtask

  task automatic test_param();
    drv_c(1'b0, 1'b0, 1'b1, 4'd0, 32'h0); cyc();
    total_cnt++;
    if ({ifc.DOUT, ifc.DOUT_VLD} !== {32'h1234_5678, 1'b1})
      $display("FAIL c_init dout=%h vld=%b want 12345678/1", ifc.DOUT, ifc.DOUT_VLD);
    else pass_cnt++;
    drv_c(1'b0, 1'b1, 1'b0, 4'd15, 32'hDEAD_BEEF); cyc();
    drv_c(1'b0, 1'b0, 1'b1, 4'd15, 32'h0); cyc();
    total_cnt++;
    if ({ifc.DOUT, ifc.DOUT_VLD, ifc.ERR} !== {32'hDEAD_BEEF, 1'b1, 1'b0})
      $display("FAIL c_rd15 dout=%h vld=%b err=%b want deadbeef/1/0", ifc.DOUT, ifc.DOUT_VLD, ifc.ERR);
    else pass_cnt++;
    drv_c(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    drv_a(1'b1, 1'b0, 1'b0, 7'd0, 8'h00);
    drv_b(1'b1, 1'b0, 1'b0, 7'd0, 8'h00);
    drv_c(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
    test_reset();
    test_clear_values();
    test_back_to_back();
    test_raw();
    test_illegal();
    test_mid_clear();
    test_param();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/data_sram_sync.md
# data_sram_sync

Parametrised, clocked data SRAM for the CPU data path. It keeps the CS_D/WD/RD/ADDR/DIN/DOUT access style of the existing data memory and adds the following:
- configurable width and depth
- a registered read port with a valid strobe
- a hardware clear sequence after reset
- error flagging for illegal or blocked accesses

It sits between the CPU load/store unit and the storage array.

## Interface
Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 7, address width in bits
- DEPTH, 128, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
- INIT_VAL, 0, DATA_W-bit value written to every word during the clear sequence

Ports:
- CLK  in  1  sole clock; all state changes on its rising edge
- RST  in  1  synchronous, active-high reset; sampled on the CLK rising edge
- CS_D  in  1  chip select, active low
- WD  in  1  write request, qualified by CS_D=0
- RD  in  1  read request, qualified by CS_D=0
- ADDR  in  ADDR_W  word address
- DIN  in  DATA_W  write data
- DOUT  out  DATA_W  registered read data; holds its value until the next successful read
- DOUT_VLD  out  1  one-cycle pulse marking new DOUT data
- BUSY  out  1  high during reset and during the clear sequence; accesses are refused while high
- ERR  out  1  one-cycle pulse marking a refused access

## Operation
- States:
  - CLEAR: writes INIT_VAL to address ptr, then ptr+1.
  - READY: serves accesses.
- Reset, at an edge with RST=1:
  - state goes to CLEAR and ptr goes to 0.
  - DOUT=0, DOUT_VLD=0, ERR=0, BUSY=1.
  - Array contents are not touched at this edge.
- CLEAR state:
  - Each edge writes mem[ptr]=INIT_VAL.
  - On the edge that writes ptr=DEPTH-1, the state moves to READY and BUSY falls.
  - CLEAR therefore takes exactly DEPTH edges.
- Request at an edge is defined as CS_D=0 and (WD|RD)=1.
- A request while BUSY=1:
  - no array access, ERR=1 for one cycle.
  - The clear sequence continues undisturbed.
- READY state, request classification:
  - WD=1 and RD=1: conflict → no access, ERR pulse.
  - ADDR >= DEPTH: out of range → no access, ERR pulse, DOUT unchanged.
  - WD=1 only: mem[ADDR] <= DIN.
  - RD=1 only: DOUT <= mem[ADDR] and DOUT_VLD=1 for one cycle.
- No request (CS_D=1, or WD=RD=0):
  - no access, DOUT holds, DOUT_VLD=0, ERR=0.
- Widths:
  - ADDR is compared unsigned against DEPTH.
  - The ptr counter is ADDR_W+1 bits wide, so DEPTH=2**ADDR_W has no wrap ambiguity.
  - When DEPTH=2**ADDR_W the out-of-range error is never raised.
- RST=1 mid-CLEAR or mid-access:
  - the clear restarts from ptr=0.
  - Any request at the same edge is dropped without ERR.

## Timing
- Write: a request sampled at edge k updates the array at edge k. A read of the same address sampled at edge k+1 returns the new data.
- Read latency is one edge: sampled at edge k, DOUT and DOUT_VLD are valid from edge k until edge k+1.
- Back-to-back reads on consecutive edges give consecutive DOUT_VLD pulses. DOUT_VLD stays high continuously and DOUT changes every cycle.
- ERR and DOUT_VLD are mutually exclusive at any edge.
- The first access is accepted at the edge following the one where BUSY fell, which is edge DEPTH+1 after reset release.
- There is no combinational path from inputs to outputs.

## Test plan
- Reset and clear:
  - Stimulus: DEPTH=128, INIT_VAL=8'hA5; hold RST 2 cycles, then release.
  - Required: BUSY=1 for exactly 128 edges after release; a read of addresses 0, 64 and 127 then returns 8'hA5 each, one edge latency, with DOUT_VLD pulses.
- Write/read:
  - Stimulus: write 8'h01 at address 0 and 8'h03 at address 1 (CS_D low one cycle each, WD=1); then read address 0, then address 1.
  - Required: DOUT=8'h01 then 8'h03 on consecutive cycles with DOUT_VLD high for 2 cycles; DOUT holds 8'h03 afterwards.
- Read-after-write:
  - Stimulus: write 8'h5C at address 10 at edge k; read address 10 at edge k+1.
  - Required: DOUT=8'h5C after edge k+1.
- Illegal accesses:
  - Stimulus 1: WD=RD=1.
  - Stimulus 2: ADDR=100 with DEPTH=96.
  - Stimulus 3: any request during BUSY.
  - Required: ERR pulses one cycle each; no array change; DOUT unchanged; DOUT_VLD=0.
- Mid-clear reset:
  - Stimulus: assert RST when ptr=50.
  - Required: BUSY stays high and the clear restarts; BUSY falls exactly DEPTH edges after RST is released.
- Parametrisation:
  - Stimulus: DATA_W=32, ADDR_W=4, DEPTH=16; write 32'hDEADBEEF to address 15, then read address 15.
  - Required: DOUT=32'hDEADBEEF.
